load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 ADDR_W, 13, word-address width driven to data memory (byte address bits [ADDR_W+1:2]).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  core requests a load/store this cycle.
REQ-005 req_write  input  1  1 = store, 0 = load.
REQ-006 req_funct3  input  3  RV32I load/store funct3.
REQ-007 req_addr  input  32  byte address (ALU result).
REQ-008 req_wdata  input  32  store data (rs2 value).
REQ-009 req_ready  output  1  unit idle, able to accept a request.
REQ-010 stall  output  1  core must hold PC and register writeback.
REQ-011 resp_valid  output  1  one-cycle pulse: access complete.
REQ-012 resp_rdata  output  32  extended load data, valid with resp_valid.
REQ-013 fault  output  1  misaligned or illegal-funct3 access, valid with resp_valid.
REQ-014 mem_en  output  1  data-memory enable.
REQ-015 mem_we  output  4  per-byte write enables.
REQ-016 mem_addr  output  ADDR_W  word address.
REQ-017 mem_wdata  output  32  lane-replicated store data.
REQ-018 mem_rdata  input  32  memory read data, valid exactly one cycle after mem_en with mem_we=0.

Function
REQ-019 The FSM SHALL have states IDLE, ACCESS, WAIT, DONE.
REQ-020 The unit SHALL assert req_ready only in IDLE.
REQ-021 On req_valid in IDLE, the unit SHALL capture write, funct3, addr and wdata; later input changes SHALL NOT affect the access.
REQ-022 A legal, aligned request SHALL move IDLE->ACCESS; in ACCESS, mem_en=1, mem_addr=addr[ADDR_W+1:2], and mem_we and mem_wdata SHALL be driven from registered state.
REQ-023 A load SHALL move ACCESS->WAIT->DONE, sampling mem_rdata in WAIT; resp_valid SHALL rise 3 cycles after acceptance.
REQ-024 A store SHALL move ACCESS->DONE; resp_valid SHALL rise 2 cycles after acceptance.
REQ-025 DONE SHALL last one cycle with resp_valid=1 and SHALL return to IDLE.
REQ-026 Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Any other funct3 SHALL be illegal.
REQ-027 Halfword access with addr[0]=1 and word access with addr[1:0]!=0 SHALL be misaligned.
REQ-028 An illegal or misaligned request SHALL go IDLE->DONE with fault=1 and resp_rdata=0; mem_en SHALL stay 0, so memory is neither read nor written.
REQ-029 Store byte enables:
- SB: mem_we=4'b0001<<addr[1:0], mem_wdata={4{wdata[7:0]}}.
- SH: mem_we=4'b0011<<{addr[1],1'b0}, mem_wdata={2{wdata[15:0]}}.
- SW: mem_we=4'b1111, mem_wdata=wdata.
REQ-030 Load extraction SHALL select the lane by addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-031 mem_we SHALL be 0 in every state except ACCESS of a store.
REQ-032 stall SHALL equal (req_valid & IDLE) | WAIT | ACCESS, deasserting in the DONE cycle so the core retires there.
REQ-033 req_valid outside IDLE SHALL be ignored; back-to-back requests SHALL have at least one IDLE cycle between them.

Reset
REQ-034 While rst=0, the state SHALL be IDLE and req_ready=1; stall, resp_valid, fault, mem_en and mem_we SHALL be 0; resp_rdata, mem_addr and mem_wdata SHALL be 0.
REQ-035 Reset asserted in ACCESS SHALL clear mem_en and mem_we immediately (asynchronously); any pending response SHALL be discarded and SHALL produce no resp_valid after release.
REQ-036 The first request SHALL be accepted on the first rising edge with rst=1.

Verification
REQ-037 SW addr=0x100, wdata=0xDEADBEEF -> ACCESS: mem_addr=0x40, mem_we=1111; resp_valid at +2, fault=0.
REQ-038 SB addr=0x103, wdata=0x000000A5 -> mem_we=1000, mem_wdata=0xA5A5A5A5.
REQ-039 mem word 0x80F0_7F01: LB addr+2 -> 0xFFFFFFF0; LBU addr+2 -> 0x000000F0; LH addr+0 -> 0x00007F01; resp_valid at +3.
REQ-040 LW addr=0x102 -> resp_valid at +1, fault=1, resp_rdata=0, mem_en never 1; funct3=011 load also faults.
REQ-041 Store accepted; rst pulsed low during ACCESS -> mem_we=0 within the same cycle, no resp_valid, req_ready=1 after release.
REQ-042 req_valid held high continuously with two loads -> second accepted only after DONE and one IDLE cycle; stall pattern 1,1,1,0 per load.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I data-memory load/store unit
// Four-state access sequencer with byte-lane steering and load extension.
module load_store_unit #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              stall,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              fault,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state;
  logic        cap_write;
  logic [2:0]  cap_funct3;
  logic [1:0]  cap_addr_lo;

  logic        req_legal;
  logic        req_misaligned;
  logic        req_ok;
  logic [3:0]  st_we;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  always_comb begin
    req_legal = 1'b0;
    if (req_write) begin
      req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    end else begin
      req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                  (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    end
    req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    req_ok = req_legal && !req_misaligned;
  end

  // Store data is replicated across lanes so memory only needs the byte enables.
  always_comb begin
    st_we    = 4'b1111;
    st_wdata = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        st_we    = 4'b0001 << req_addr[1:0];
        st_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_we    = 4'b0011 << {req_addr[1], 1'b0};
        st_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        st_we    = 4'b1111;
        st_wdata = req_wdata;
      end
    endcase
  end

  assign ld_byte = mem_rdata[{cap_addr_lo, 3'b000} +: 8];
  assign ld_half = mem_rdata[{cap_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = mem_rdata;
    case (cap_funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cap_write   <= 1'b0;
      cap_funct3  <= 3'b000;
      cap_addr_lo <= 2'b00;
      resp_valid  <= 1'b0;
      resp_rdata  <= 32'd0;
      fault       <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 4'b0000;
      mem_addr    <= '0;
      mem_wdata   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_write   <= req_write;
            cap_funct3  <= req_funct3;
            cap_addr_lo <= req_addr[1:0];
            if (req_ok) begin
              state    <= ACCESS;
              mem_en   <= 1'b1;
              mem_addr <= req_addr[ADDR_W+1:2];
              if (req_write) begin
                mem_we    <= st_we;
                mem_wdata <= st_wdata;
              end
            end else begin
              // Rejected accesses never touch memory; respond with a fault next cycle.
              state      <= DONE;
              resp_valid <= 1'b1;
              fault      <= 1'b1;
              resp_rdata <= 32'd0;
            end
          end
        end
        ACCESS: begin
          mem_en <= 1'b0;
          mem_we <= 4'b0000;
          if (cap_write) begin
            state      <= DONE;
            resp_valid <= 1'b1;
            fault      <= 1'b0;
            resp_rdata <= 32'd0;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          state      <= DONE;
          resp_valid <= 1'b1;
          fault      <= 1'b0;
          resp_rdata <= ld_data;
        end
        DONE: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          fault      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign stall     = rst && ((req_valid && (state == IDLE)) || (state == WAIT) || (state == ACCESS));

endmodule
